// File: rtl/stream_router.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stream_router
//   Routes one AXI4-Stream sample input to one of two AXI4-Stream outputs
//   (A or B) selected by the `switch` level. Each output has a one-deep
//   register slice. A change of destination waits until the old slice has
//   drained, so no sample is lost, duplicated or split across outputs.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   switch                 destination select level (0 = A, 1 = B)
//   s_axis_*               input stream (tdata / tvalid / tready)
//   m_axis_a_*, m_axis_b_* output streams (tdata / tvalid / tready)
//   active                 destination currently routed (0 = A, 1 = B)
// -----------------------------------------------------------------------------
module stream_router #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  switch,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_a_tdata,
  output logic                  m_axis_a_tvalid,
  input  logic                  m_axis_a_tready,
  output logic [DATA_WIDTH-1:0] m_axis_b_tdata,
  output logic                  m_axis_b_tvalid,
  input  logic                  m_axis_b_tready,
  output logic                  active
);

  typedef enum logic [1:0] {
    SEL_A   = 2'd0,
    DRAIN_A = 2'd1,
    SEL_B   = 2'd2,
    DRAIN_B = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  switch_q, switch_d;
  logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
  logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
  logic                  a_valid_q, a_valid_d;
  logic                  b_valid_q, b_valid_d;

  // A slice has room when it is empty or its content leaves on this edge.
  logic a_room, b_room;
  logic load_a, load_b;

  assign a_room = !a_valid_q || m_axis_a_tready;
  assign b_room = !b_valid_q || m_axis_b_tready;

  // Only the selected slice ever loads; the drain states block the input.
  assign load_a = (state_q == SEL_A) && s_axis_tvalid && a_room;
  assign load_b = (state_q == SEL_B) && s_axis_tvalid && b_room;

  // The only combinational input-to-output path: tready through to s_axis_tready.
  assign s_axis_tready = ((state_q == SEL_A) && a_room) ||
                         ((state_q == SEL_B) && b_room);

  assign m_axis_a_tdata  = a_data_q;
  assign m_axis_a_tvalid = a_valid_q;
  assign m_axis_b_tdata  = b_data_q;
  assign m_axis_b_tvalid = b_valid_q;
  assign active          = (state_q == SEL_B) || (state_q == DRAIN_B);

  // Routing FSM. Decisions use the registered switch only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    switch_d = switch;
    state_d  = state_q;
    unique case (state_q)
      SEL_A:   if (switch_q) state_d = DRAIN_A;
      DRAIN_A: begin
        // A glitch back to A aborts the change; otherwise wait for A to empty.
        if (!switch_q)    state_d = SEL_A;
        else if (a_room)  state_d = SEL_B;
      end
      SEL_B:   if (!switch_q) state_d = DRAIN_B;
      DRAIN_B: begin
        if (switch_q)     state_d = SEL_B;
        else if (b_room)  state_d = SEL_A;
      end
      default:            state_d = SEL_A;
    endcase
  end

  // Register slices: a load wins over a same-cycle output handshake, so
  // tvalid stays high when a new sample replaces the departing one.
  always_comb begin
    a_data_d  = a_data_q;
    a_valid_d = a_valid_q;
    b_data_d  = b_data_q;
    b_valid_d = b_valid_q;
    if (load_a) begin
      a_data_d  = s_axis_tdata;
      a_valid_d = 1'b1;
    end else if (a_valid_q && m_axis_a_tready) begin
      a_valid_d = 1'b0;
    end
    if (load_b) begin
      b_data_d  = s_axis_tdata;
      b_valid_d = 1'b1;
    end else if (b_valid_q && m_axis_b_tready) begin
      b_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= SEL_A;
      switch_q  <= 1'b0;
      a_data_q  <= '0;
      a_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      switch_q  <= switch_d;
      a_data_q  <= a_data_d;
      a_valid_q <= a_valid_d;
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
    end
  end

endmodule

// File: tb/tb_stream_router.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_stream_router
//   Self-checking bench for stream_router. Inputs change 1 ns after the
//   rising edge; outputs are observed on the falling edge. A scoreboard queue
//   receives every accepted input sample and is popped, in order, by every
//   output handshake on either A or B.
// -----------------------------------------------------------------------------
module tb_stream_router;

  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          switch;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_a_tdata;
  logic          m_axis_a_tvalid;
  logic          m_axis_a_tready;
  logic [DW-1:0] m_axis_b_tdata;
  logic          m_axis_b_tvalid;
  logic          m_axis_b_tready;
  logic          active;

  stream_router #(.DATA_WIDTH(DW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .switch          (switch),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axis_a_tdata  (m_axis_a_tdata),
    .m_axis_a_tvalid (m_axis_a_tvalid),
    .m_axis_a_tready (m_axis_a_tready),
    .m_axis_b_tdata  (m_axis_b_tdata),
    .m_axis_b_tvalid (m_axis_b_tvalid),
    .m_axis_b_tready (m_axis_b_tready),
    .active          (active)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int passed = 0;

  // Scoreboard and monitor state.
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_d;
  logic [DW-1:0] pa_d, pb_d;
  logic          pa_v, pa_r, pb_v, pb_r, prev_ok;
  int            hs_a = 0;
  int            hs_b = 0;

  initial prev_ok = 1'b0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      sb_q.delete();
      prev_ok = 1'b0;
    end else begin
      // A stalled output must keep tvalid and tdata unchanged.
      if (prev_ok && pa_v && !pa_r) begin
        checks++;
        if (m_axis_a_tvalid !== 1'b1 || m_axis_a_tdata !== pa_d)
          $display("FAIL a_hold: got v=%b d=%h, expected v=1 d=%h", m_axis_a_tvalid, m_axis_a_tdata, pa_d);
        else passed++;
      end
      if (prev_ok && pb_v && !pb_r) begin
        checks++;
        if (m_axis_b_tvalid !== 1'b1 || m_axis_b_tdata !== pb_d)
          $display("FAIL b_hold: got v=%b d=%h, expected v=1 d=%h", m_axis_b_tvalid, m_axis_b_tdata, pb_d);
        else passed++;
      end
      // Output handshakes pop in input order, whichever output emits.
      if (m_axis_a_tvalid && m_axis_a_tready) begin
        hs_a++;
        checks++;
        if (sb_q.size() == 0) $display("FAIL a_order: got %h, expected nothing (scoreboard empty)", m_axis_a_tdata);
        else begin
          exp_d = sb_q.pop_front();
          if (m_axis_a_tdata !== exp_d) $display("FAIL a_order: got %h, expected %h", m_axis_a_tdata, exp_d);
          else passed++;
        end
      end
      if (m_axis_b_tvalid && m_axis_b_tready) begin
        hs_b++;
        checks++;
        if (sb_q.size() == 0) $display("FAIL b_order: got %h, expected nothing (scoreboard empty)", m_axis_b_tdata);
        else begin
          exp_d = sb_q.pop_front();
          if (m_axis_b_tdata !== exp_d) $display("FAIL b_order: got %h, expected %h", m_axis_b_tdata, exp_d);
          else passed++;
        end
      end
      if (s_axis_tvalid && s_axis_tready) sb_q.push_back(s_axis_tdata);
      pa_v = m_axis_a_tvalid; pa_r = m_axis_a_tready; pa_d = m_axis_a_tdata;
      pb_v = m_axis_b_tvalid; pb_r = m_axis_b_tready; pb_d = m_axis_b_tdata;
      prev_ok = 1'b1;
    end
  end

  // Bounded wait (in cycles) for `active` to reach a value.
  task automatic wait_active(input logic v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      if (active === v) begin ok = 1'b1; break; end
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge aclk); #1; end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; switch = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    #12;
    checks++;
    if ({m_axis_a_tvalid, m_axis_b_tvalid, active} !== 3'b000 || m_axis_a_tdata !== '0 || m_axis_b_tdata !== '0)
      $display("FAIL reset_state: got av=%b bv=%b act=%b ad=%h bd=%h, expected all 0",
               m_axis_a_tvalid, m_axis_b_tvalid, active, m_axis_a_tdata, m_axis_b_tdata);
    else passed++;
    @(posedge aclk); #1; aresetn = 1'b1;
    idle(1);
  endtask

  task automatic test_stream_a();
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'd14;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++;
      if (s_axis_tready !== 1'b1) $display("FAIL stream_a_ready[%0d]: got %b, expected 1", i, s_axis_tready);
      else passed++;
      @(posedge aclk); #1;
      if (i < 2) s_axis_tdata = 16'(15 + i); else s_axis_tvalid = 1'b0;
      @(negedge aclk);
      checks++;
      if (m_axis_a_tvalid !== 1'b1 || m_axis_a_tdata !== 16'(14 + i) || m_axis_b_tvalid !== 1'b0 || active !== 1'b0)
        $display("FAIL stream_a[%0d]: got av=%b ad=%0d bv=%b act=%b, expected av=1 ad=%0d bv=0 act=0",
                 i, m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, active, 14 + i);
      else passed++;
    end
    idle(2);
  endtask

  task automatic test_stall_switch();
    bit got;
    bit ok;
    m_axis_a_tready = 1'b0; m_axis_b_tready = 1'b1; switch = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'd14;
    @(posedge aclk); #1;
    switch = 1'b1; s_axis_tdata = 16'hFFE3;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      checks++;
      if (s_axis_tready !== 1'b0 || m_axis_a_tvalid !== 1'b1 || m_axis_a_tdata !== 16'd14 || m_axis_b_tvalid !== 1'b0)
        $display("FAIL stall[%0d]: got sr=%b av=%b ad=%h bv=%b, expected sr=0 av=1 ad=000e bv=0",
                 i, s_axis_tready, m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid);
      else passed++;
      @(posedge aclk); #1;
    end
    m_axis_a_tready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (s_axis_tvalid && s_axis_tready) got = 1'b1;
      @(posedge aclk); #1;
      if (got) begin s_axis_tvalid = 1'b0; break; end
    end
    @(negedge aclk);
    checks++;
    if (!got || m_axis_b_tvalid !== 1'b1 || m_axis_b_tdata !== 16'hFFE3 || active !== 1'b1 || m_axis_a_tvalid !== 1'b0)
      $display("FAIL switch_to_b: got acc=%b bv=%b bd=%h act=%b av=%b, expected acc=1 bv=1 bd=ffe3 act=1 av=0",
               got, m_axis_b_tvalid, m_axis_b_tdata, active, m_axis_a_tvalid);
    else passed++;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    switch = 1'b0;
    wait_active(1'b0, ok);
    checks++;
    if (!ok) $display("FAIL back_to_a: got act=%b, expected 0 within 12 cycles", active);
    else passed++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    int max_gap = 0;
    int n_acc = 0;
    int a0 = hs_a;
    int b0 = hs_b;
    bit acc;
    logic [DW-1:0] d = 16'h1000;
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1; switch = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d;
    for (int c = 0; c < 60; c++) begin
      @(negedge aclk);
      acc = s_axis_tvalid && s_axis_tready;
      if (acc) begin n_acc++; gap = 0; end
      else begin gap++; if (gap > max_gap) max_gap = gap; end
      @(posedge aclk); #1;
      if (acc) begin d++; s_axis_tdata = d; end
      if (c % 10 == 9) switch = ~switch;
    end
    s_axis_tvalid = 1'b0;
    idle(8);
    checks++;
    if (max_gap > 2) $display("FAIL toggle_gap: got max gap %0d, expected <= 2", max_gap);
    else passed++;
    checks++;
    if (n_acc < 48) $display("FAIL toggle_rate: got %0d accepts in 60 cycles, expected >= 48", n_acc);
    else passed++;
    checks++;
    if (hs_a - a0 == 0 || hs_b - b0 == 0 || (hs_a - a0) + (hs_b - b0) != n_acc)
      $display("FAIL toggle_split: got a=%0d b=%0d, expected both nonzero summing to %0d", hs_a - a0, hs_b - b0, n_acc);
    else passed++;
  endtask

  task automatic test_glitch();
    m_axis_a_tready = 1'b0; m_axis_b_tready = 1'b1; switch = 1'b0;
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'd77;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0; switch = 1'b1;
    idle(2);                 // registered, then DRAIN_A
    switch = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      checks++;
      if (active !== 1'b0 || m_axis_b_tvalid !== 1'b0 || m_axis_a_tvalid !== 1'b1 || m_axis_a_tdata !== 16'd77)
        $display("FAIL glitch[%0d]: got act=%b bv=%b av=%b ad=%0d, expected act=0 bv=0 av=1 ad=77",
                 i, active, m_axis_b_tvalid, m_axis_a_tvalid, m_axis_a_tdata);
      else passed++;
      @(posedge aclk); #1;
    end
    // Back in SEL_A: a new sample loads in the same cycle 77 leaves.
    m_axis_a_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 16'd78;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b1) $display("FAIL glitch_ready: got %b, expected 1", s_axis_tready);
    else passed++;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (m_axis_a_tvalid !== 1'b1 || m_axis_a_tdata !== 16'd78 || m_axis_b_tvalid !== 1'b0)
      $display("FAIL load_wins: got av=%b ad=%0d bv=%b, expected av=1 ad=78 bv=0", m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid);
    else passed++;
    idle(3);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [2:0] act_seq;
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b0; switch = 1'b1;
    wait_active(1'b1, ok);
    checks++;
    if (!ok) $display("FAIL rst_setup: got act=%b, expected 1 within 12 cycles", active);
    else passed++;
    s_axis_tvalid = 1'b1; s_axis_tdata = 16'h5A5A;
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    checks++;
    if (m_axis_b_tvalid !== 1'b1 || m_axis_b_tdata !== 16'h5A5A)
      $display("FAIL rst_loaded: got bv=%b bd=%h, expected bv=1 bd=5a5a", m_axis_b_tvalid, m_axis_b_tdata);
    else passed++;
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_axis_a_tvalid, m_axis_b_tvalid, active} !== 3'b000 || m_axis_a_tdata !== '0 || m_axis_b_tdata !== '0)
      $display("FAIL rst_async: got av=%b bv=%b act=%b ad=%h bd=%h, expected all 0",
               m_axis_a_tvalid, m_axis_b_tvalid, active, m_axis_a_tdata, m_axis_b_tdata);
    else passed++;
    @(posedge aclk); #1;
    aresetn = 1'b1;           // switch is still 1
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      act_seq[i] = active;
    end
    checks++;
    if (act_seq !== 3'b100) $display("FAIL rst_resume: got active after edges 1..3 = %b%b%b, expected 001",
                                     act_seq[0], act_seq[1], act_seq[2]);
    else passed++;
    m_axis_b_tready = 1'b1;
    @(posedge aclk); #1;
    switch = 1'b0;
    wait_active(1'b0, ok);
    checks++;
    if (!ok) $display("FAIL rst_back_a: got act=%b, expected 0 within 12 cycles", active);
    else passed++;
  endtask

  task automatic test_random();
    bit acc;
    int n_acc = 0;
    int h0 = hs_a + hs_b;
    logic [DW-1:0] d = 16'h7FF0;
    s_axis_tvalid = 1'b0; s_axis_tdata = d;
    for (int c = 0; c < 10000; c++) begin
      @(negedge aclk);
      acc = s_axis_tvalid && s_axis_tready;
      if (acc) n_acc++;
      @(posedge aclk); #1;
      // The source holds tvalid/tdata until accepted.
      if (acc || !s_axis_tvalid) begin
        if (acc) d++;
        s_axis_tdata  = d;
        s_axis_tvalid = ($urandom_range(0, 3) != 0);
      end
      m_axis_a_tready = ($urandom_range(0, 3) != 0);
      m_axis_b_tready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) switch = ~switch;
    end
    s_axis_tvalid = 1'b0; m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (sb_q.size() == 0 && !m_axis_a_tvalid && !m_axis_b_tvalid) break;
      @(posedge aclk); #1;
    end
    checks++;
    if (sb_q.size() != 0) $display("FAIL rand_drain: got %0d samples outstanding, expected 0", sb_q.size());
    else passed++;
    checks++;
    if ((hs_a + hs_b) - h0 != n_acc) $display("FAIL rand_count: got %0d outputs, expected %0d", (hs_a + hs_b) - h0, n_acc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream_a();
    test_stall_switch();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by 400 us, expected completion");
    $fatal(1, "timeout");
  end

endmodule
